// File: rtl/ps2transmitter_if.sv
// rtl/ps2transmitter_if.sv - command handshake and PS/2 pad signals of the host transmitter
interface ps2transmitter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_start, tx_data, ps2_clk, ps2_data,
    input  ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_start, tx_data, ps2_clk, ps2_data,
    output ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2transmitter.sv
// rtl/ps2transmitter.sv - PS/2 host-to-device command transmitter
// Clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, then device ACK check.
module ps2transmitter #(
  parameter int INHIBIT_CYCLES     = 3000,
  parameter int START_CYCLES       = 56,
  parameter int FIRST_EDGE_TIMEOUT = 420000,
  parameter int BIT_TIMEOUT        = 2900
) (
  input  logic            clk,
  input  logic            rst_n,
  ps2transmitter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_WAIT_IDLE,
    S_ERROR
  } state_t;

  localparam logic [19:0] INHIBIT_LD = 20'(INHIBIT_CYCLES);
  localparam logic [19:0] START_LD   = 20'(START_CYCLES);
  localparam logic [19:0] FIRST_LD   = 20'(FIRST_EDGE_TIMEOUT);
  localparam logic [19:0] BIT_LD     = 20'(BIT_TIMEOUT);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic [10:0] frame_q, frame_d;
  logic [7:0]  clk_sr_q, clk_sr_d;
  logic        clk_filt_q, clk_filt_d;
  logic        data_meta_q, data_meta_d;
  logic        data_sync_q, data_sync_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        clk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      edge_cnt_q  <= '0;
      frame_q     <= '0;
      clk_sr_q    <= 8'hFF;
      clk_filt_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      frame_q     <= frame_d;
      clk_sr_q    <= clk_sr_d;
      clk_filt_q  <= clk_filt_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next state, watchdog/phase counter, clock filter and data synchronizer.
  always_comb begin
    clk_sr_d    = {clk_sr_q[6:0], bus.ps2_clk};
    clk_filt_d  = clk_filt_q;
    if (clk_sr_q == 8'h00) begin
      clk_filt_d = 1'b0;
    end else if (clk_sr_q == 8'hFF) begin
      clk_filt_d = 1'b1;
    end
    clk_fall    = clk_filt_q & ~clk_filt_d;
    data_meta_d = bus.ps2_data;
    data_sync_d = data_meta_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    frame_d    = frame_q;

    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          // frame_q[0] is the start bit; each device falling edge shifts the next bit down.
          frame_d = {1'b1, ~^bus.tx_data, bus.tx_data, 1'b0};
          cnt_d   = INHIBIT_LD;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q <= 20'd1) begin
          cnt_d   = START_LD;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_START: begin
        if (cnt_q <= 20'd1) begin
          cnt_d      = FIRST_LD;
          edge_cnt_d = '0;
          state_d    = S_SEND;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_SEND: begin
        if (clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          cnt_d      = BIT_LD;
          frame_d    = {1'b1, frame_q[10:1]};
          if (edge_cnt_q == 4'd10) begin
            state_d = data_sync_q ? S_ERROR : S_WAIT_IDLE;
          end
        end else if (cnt_q <= 20'd1) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_filt_q && data_sync_q) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 20'd1) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs; busy/done/error look at state_d so they line up with the IDLE return.
  always_comb begin
    clk_oe_d  = (state_q == S_INHIBIT) || (state_q == S_START);
    data_oe_d = (state_q == S_START) || ((state_q == S_SEND) && !frame_q[0]);
    busy_d    = (state_q != S_IDLE) && (state_d != S_IDLE);
    done_d    = (state_q == S_WAIT_IDLE) && (state_d == S_IDLE);
    error_d   = (state_q == S_ERROR);
  end

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_error    = error_q;

endmodule

// File: tb/tb_ps2transmitter.sv
// tb/tb_ps2transmitter.sv - directed bench for ps2transmitter with a PS/2 device model
module tb_ps2transmitter;
  localparam int INH  = 20;
  localparam int STC  = 5;
  localparam int FET  = 300;
  localparam int BTO  = 100;
  localparam int LOW  = 20;
  localparam int HIGH = 20;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [9:0] exp_seq;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  ps2transmitter_if bus();

  ps2transmitter #(
    .INHIBIT_CYCLES    (INH),
    .START_CYCLES      (STC),
    .FIRST_EDGE_TIMEOUT(FET),
    .BIT_TIMEOUT       (BTO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.ps2_clk  = ~(bus.ps2_clk_oe | dev_clk_low | glitch_low);
  assign bus.ps2_data = ~(bus.ps2_data_oe | dev_data_low);

  always @(negedge clk) begin
    if (bus.tx_done)  done_cnt <= done_cnt + 1;
    if (bus.tx_error) err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Requests a byte and checks the inhibit/start timing up to clock release.
  task automatic start_frame(input logic [7:0] d);
    int w;
    int hi;
    int d_first;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    w = 0;
    while (!bus.ps2_clk_oe && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("clk_oe_rise_latency", w, 1);
    check("busy_after_accept", bus.tx_busy, 1'b1);
    hi = 0;
    d_first = 0;
    while (bus.ps2_clk_oe && hi < 500) begin
      hi++;
      if (bus.ps2_data_oe && d_first == 0) d_first = hi;
      @(negedge clk);
    end
    check("clk_oe_high_cycles", hi, INH + STC);
    check("data_oe_rise_offset", d_first, INH + 1);
    check("start_bit_after_release", bus.ps2_data_oe, 1'b1);
  endtask

  task automatic dev_edge(input bit glitch, input bit inject, output logic oe);
    dev_clk_low = 1'b1;
    for (int c = 0; c < LOW; c++) begin
      if (inject) begin
        bus.tx_start = (c == 0);
        bus.tx_data  = 8'h12;
      end
      @(negedge clk);
    end
    bus.tx_start = 1'b0;
    oe = bus.ps2_data_oe;
    dev_clk_low = 1'b0;
    for (int c = 0; c < HIGH; c++) begin
      glitch_low = glitch && (c >= 11) && (c < 14);
      @(negedge clk);
    end
    glitch_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic ack, input bit glitch,
                           input bit inject, output logic [9:0] seq);
    logic oe;
    int   w;
    seq = '0;
    start_frame(d);
    repeat (15) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      dev_data_low = ack && (e == 11);
      dev_edge(glitch && (e >= 2) && (e <= 9), inject && (e == 3), oe);
      if (e <= 10) seq[e-1] = oe;
    end
    dev_data_low = 1'b0;
    w = 0;
    while (bus.tx_busy && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("busy_released", bus.tx_busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[5];
    logic [9:0] seq;
    logic       oe;
    int         d0;
    int         e0;
    int         cnt;

    vecs[0] = '{8'hED, 1'b1, 10'h012, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 10'h0FF, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 10'h000, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 10'h1FE, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, 10'h05A, 0, 1};

    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", bus.ps2_clk_oe, 1'b0);
    check("reset_data_oe", bus.ps2_data_oe, 1'b0);
    check("reset_busy", bus.tx_busy, 1'b0);
    check("reset_done", bus.tx_done, 1'b0);
    check("reset_error", bus.tx_error, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[i].data, vecs[i].ack, 1'b0, 1'b0, seq);
      check($sformatf("vec%0d_data_oe_seq", i), seq, vecs[i].exp_seq);
      check($sformatf("vec%0d_done_pulses", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_error_pulses", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_idle_oe", i), {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
    end

    // A second request mid-frame must not alter the wire or start another frame.
    d0 = done_cnt;
    run_frame(8'hED, 1'b1, 1'b0, 1'b1, seq);
    check("inject_data_oe_seq", seq, 10'h012);
    check("inject_done_pulses", done_cnt - d0, 1);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.ps2_clk_oe || bus.tx_busy) cnt++;
    end
    check("inject_no_second_frame", cnt, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'h3C, 1'b1, 1'b1, 1'b0, seq);
    check("glitch_data_oe_seq", seq, 10'h0C3);
    check("glitch_done_pulses", done_cnt - d0, 1);
    check("glitch_error_pulses", err_cnt - e0, 0);

    // Device never clocks after release.
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'hC3);
    cnt = 0;
    while (!bus.tx_error && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("first_edge_timeout_cycles", cnt, FET);
    check("first_edge_timeout_busy", bus.tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    check("first_edge_timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
    check("first_edge_timeout_done", done_cnt - d0, 0);
    check("first_edge_timeout_errors", err_cnt - e0, 1);

    // Device clock stalls after the fifth falling edge.
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'h55);
    repeat (15) @(negedge clk);
    for (int e = 1; e <= 4; e++) dev_edge(1'b0, 1'b0, oe);
    dev_clk_low = 1'b1;
    cnt = 0;
    while (!bus.tx_error && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (cnt == LOW) dev_clk_low = 1'b0;
    end
    dev_clk_low = 1'b0;
    check("bit_timeout_cycles", cnt, BTO + 10);
    repeat (3) @(negedge clk);
    check("bit_timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
    check("bit_timeout_done", done_cnt - d0, 0);
    check("bit_timeout_errors", err_cnt - e0, 1);

    // Asynchronous reset in the middle of SEND.
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'h81);
    repeat (15) @(negedge clk);
    for (int e = 1; e <= 3; e++) dev_edge(1'b0, 1'b0, oe);
    check("pre_reset_data_oe", bus.ps2_data_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_data_oe", bus.ps2_data_oe, 1'b0);
    check("async_reset_clk_oe", bus.ps2_clk_oe, 1'b0);
    check("async_reset_busy", bus.tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("reset_drop_done", done_cnt - d0, 0);
    check("reset_drop_errors", err_cnt - e0, 0);
    check("reset_drop_busy", bus.tx_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
